gray_wptr_gen: RTL and testbench

- Write-side pointer generator for the dual-clock FIFO; the encoding end of the Gray pointer path.
- Keeps a binary write pointer and publishes it as a registered Gray pointer for crossing into the read domain.
- Takes the read pointer in Gray, decodes it, and produces a registered full flag and fill level.
- Sits between the FIFO write port and the dual-port RAM write address.

---
 rtl/gray_wptr_gen_pkg.sv | 31 +++
 rtl/gray_wptr_gen_sync_2ff.sv | 34 +++
 rtl/gray_wptr_gen.sv | 91 +++++++++
 tb/tb_gray_wptr_gen.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/gray_wptr_gen_pkg.sv
// ============================================================================
// Module   : gray_wptr_gen_pkg
// Purpose  : Shared Gray/binary conversion helpers and default pointer width
//            for the dual-clock FIFO pointer path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_wptr_gen_pkg;

  localparam int FIFO_PTR_DEFAULT = 8;
  localparam int GRAY_MAX_W       = 32;

  // Operands of any width up to GRAY_MAX_W are passed zero-extended; the
  // zero upper bits leave the result of both conversions unchanged.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_wptr_gen_sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for a Gray-coded bus, reset to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/gray_wptr_gen.sv
// ============================================================================
// Module   : gray_wptr_gen
// Purpose  : FIFO write-side pointer generator: binary/Gray write pointer,
//            full flag and fill level. GRAY_WPTR_SYNC_EN adds a 2-flop
//            synchronizer on rptr_gray.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_wptr_gen
  import gray_wptr_gen_pkg::*;
#(
  parameter int PTR = FIFO_PTR_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [PTR:0] rptr_gray,
  output logic [PTR-1:0] waddr,
  output logic [PTR:0] wptr_bin,
  output logic [PTR:0] wptr_gray,
  output logic         full,
  output logic [PTR:0] wlevel
);

  localparam int W = PTR + 1;

  logic [PTR:0] w_rptr_s;

`ifdef GRAY_WPTR_SYNC_EN
  sync_2ff #(
    .WIDTH (W)
  ) u_rptr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rptr_gray),
    .q     (w_rptr_s)
  );
`else
  assign w_rptr_s = rptr_gray;
`endif

  logic [PTR:0] wptr_bin_q,  wptr_bin_d;
  logic [PTR:0] wptr_gray_q, wptr_gray_d;
  logic         full_q,      full_d;
  logic [PTR:0] wlevel_q,    wlevel_d;

  logic                  w_inc;
  logic [GRAY_MAX_W-1:0] w_gray_ext;
  logic [GRAY_MAX_W-1:0] w_rbin_ext;
  logic [PTR:0]          w_rbin;
  logic                  w_unused_ext;

  assign w_inc      = wr_en & ~full_q;
  assign w_gray_ext = bin2gray(GRAY_MAX_W'(wptr_bin_d));
  assign w_rbin_ext = gray2bin(GRAY_MAX_W'(w_rptr_s));
  assign w_rbin     = w_rbin_ext[PTR:0];
  assign w_unused_ext = ^{w_gray_ext[GRAY_MAX_W-1:W], w_rbin_ext[GRAY_MAX_W-1:W]};

  always_comb begin
    wptr_bin_d  = wptr_bin_q + {{PTR{1'b0}}, w_inc};
    wptr_gray_d = w_gray_ext[PTR:0];
    // Write pointer is one full lap ahead of the read pointer: in Gray that is
    // the top two bits inverted and the rest equal.
    full_d      = (wptr_gray_d == {~w_rptr_s[PTR], ~w_rptr_s[PTR-1], w_rptr_s[PTR-2:0]});
    wlevel_d    = wptr_bin_d - w_rbin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_bin_q  <= '0;
      wptr_gray_q <= '0;
      full_q      <= 1'b0;
      wlevel_q    <= '0;
    end else begin
      wptr_bin_q  <= wptr_bin_d;
      wptr_gray_q <= wptr_gray_d;
      full_q      <= full_d;
      wlevel_q    <= wlevel_d;
    end
  end

  assign waddr     = wptr_bin_q[PTR-1:0];
  assign wptr_bin  = wptr_bin_q;
  assign wptr_gray = wptr_gray_q;
  assign full      = full_q;
  assign wlevel    = wlevel_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_wptr_gen.sv
// ============================================================================
// Module   : tb_gray_wptr_gen
// Purpose  : Scoreboard bench for gray_wptr_gen against an occupancy-count
//            reference model (handles GRAY_WPTR_SYNC_EN builds too).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_wptr_gen;

  localparam int PTR   = 2;
  localparam int DEPTH = 1 << PTR;
  localparam int MOD   = 2 * DEPTH;
`ifdef GRAY_WPTR_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wr_en;
  logic [PTR:0]   rptr_gray;
  logic [PTR-1:0] waddr;
  logic [PTR:0]   wptr_bin;
  logic [PTR:0]   wptr_gray;
  logic           full;
  logic [PTR:0]   wlevel;

  gray_wptr_gen #(.PTR(PTR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .rptr_gray (rptr_gray),
    .waddr     (waddr),
    .wptr_bin  (wptr_bin),
    .wptr_gray (wptr_gray),
    .full      (full),
    .wlevel    (wlevel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int gray;
    int full;
    int lvl;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: counts of writes/reads as plain integers modulo 2*DEPTH.
  int m_w, m_rd, m_s1, m_s2, m_lvl;
  bit m_full;
  int prev_bin, prev_gray;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_w = 0; m_rd = 0; m_s1 = 0; m_s2 = 0; m_lvl = 0; m_full = 0;
    prev_bin = 0; prev_gray = 0;
  endtask

  task automatic step(input bit wr, input bit rd_req);
    int r_used;
    exp_t e;
    @(negedge clk);
    if (rd_req && m_rd != m_w) m_rd = (m_rd + 1) % MOD;
    rptr_gray = (PTR+1)'(to_gray(m_rd));
    wr_en     = wr;
    if (SYNC != 0) begin
      r_used = m_s2;
      m_s2   = m_s1;
      m_s1   = m_rd;
    end else begin
      r_used = m_rd;
    end
    if (wr && !m_full) m_w = (m_w + 1) % MOD;
    m_lvl  = (m_w - r_used + MOD) % MOD;
    m_full = (m_lvl == DEPTH);
    e.bin = m_w; e.gray = to_gray(m_w); e.full = int'(m_full); e.lvl = m_lvl;
    sbq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("wptr_bin",  wptr_bin,  e.bin);
        chk("waddr",     waddr,     e.bin % DEPTH);
        chk("wptr_gray", wptr_gray, e.gray);
        chk("full",      full,      e.full);
        chk("wlevel",    wlevel,    e.lvl);
        if (int'(wptr_bin) != prev_bin)
          chk("gray_one_bit_step", $countones(wptr_gray ^ (PTR+1)'(prev_gray)), 1);
        prev_bin  = int'(wptr_bin);
        prev_gray = int'(wptr_gray);
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0; wr_en = 1'b0; rptr_gray = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_bin",   wptr_bin,  0);
    chk("reset_gray",  wptr_gray, 0);
    chk("reset_full",  full,      0);
    chk("reset_level", wlevel,    0);
    rst_n = 1'b1;

    // Fill from empty, then hammer while full.
    repeat (4) step(1'b1, 1'b0);
    @(posedge clk); #2;
    chk("fill_gray_110", wptr_gray, 3'b110);
    chk("fill_full",     full,      1);
    chk("fill_level",    wlevel,    DEPTH);
    repeat (3) step(1'b1, 1'b0);
    @(posedge clk); #2;
    chk("hold_bin_100", wptr_bin, 3'b100);
    chk("hold_waddr",   waddr,    0);

    // One read from full, wait for it to propagate, then refill.
    step(1'b0, 1'b1);
    repeat (SYNC) step(1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b1);
    repeat (SYNC + 1) step(1'b0, 1'b0);

    // Alternate writes and reads past the pointer wrap.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
    end

    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));

    // Asynchronous reset between clock edges.
    @(posedge clk); #3;
    rst_n = 1'b0; wr_en = 1'b0; rptr_gray = '0;
    #1;
    chk("async_rst_bin",   wptr_bin,  0);
    chk("async_rst_gray",  wptr_gray, 0);
    chk("async_rst_full",  full,      0);
    chk("async_rst_level", wlevel,    0);
    sbq.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    @(posedge clk); #2;
    chk("post_rst_gray_001", wptr_gray, 3'b001);

    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));

    @(posedge clk); #2;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
